// File: rtl/j_seq_pkg.sv
// Shared types and helpers for the j_MX_cell array sequencer.
// Holds the FSM state enum, the control-bundle width and the sizing functions.
package j_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOADW,
        STREAM,
        DRAIN,
        DONE
    } seq_state_t;

    // One row's control bundle: {clr[3:0], end[3:0], mac[3:0]}.
    localparam int SKEW_W = 12;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Cycles for the last wavefront to leave the bottom-right corner.
    function automatic int drain_len(input int height, input int width);
        return height + width - 1;
    endfunction

endpackage

// File: rtl/j_array_sequencer_row_skew.sv
// j_row_skew: depth-N delay line for one row's 12-bit control bundle.
// N=0 is a plain wire; otherwise every stage shifts on every clock.
module j_row_skew
    import j_seq_pkg::*;
#(
    parameter int N = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SKEW_W-1:0] din,
    output logic [SKEW_W-1:0] dout
);

    if (N == 0) begin : g_pass
        logic unused_clk_reset;
        assign unused_clk_reset = clk ^ reset;
        assign dout = din;
    end else begin : g_shift
        logic [SKEW_W-1:0] stage_q [N];

        // NOTE: every stage is reset, not just the output, so an aborted job
        // cannot leave stale control bits marching out after reset.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < N; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= din;
                for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign dout = stage_q[N-1];
    end

endmodule

// File: rtl/j_array_sequencer.sv
// Job sequencer for the bit-serial j_MX_cell subarray: weight load, vector
// streaming with per-row skew, drain and done. Optional macro: J_SEQ_PERF_CNT_EN.
module j_array_sequencer
    import j_seq_pkg::*;
#(
    parameter int SUBARRAY_WIDTH  = 1,
    parameter int SUBARRAY_HEIGHT = 1,
    parameter int SERIAL_LEN      = 8,
    parameter int W_NVEC          = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [W_NVEC-1:0]            cmd_nvec,
    input  logic [3:0]                   cmd_lane_mask,
    output logic [SUBARRAY_WIDTH-1:0]    update_w,
    output logic [4*SUBARRAY_HEIGHT-1:0] clr_and_plus_one,
    output logic [4*SUBARRAY_HEIGHT-1:0] serial_end,
    output logic [4*SUBARRAY_HEIGHT-1:0] mac_en,
    output logic                         busy,
`ifdef J_SEQ_PERF_CNT_EN
    output logic [31:0]                  perf_cycles,
    output logic [15:0]                  perf_jobs,
`endif
    output logic                         done
);

    localparam int DRAIN_LEN = drain_len(SUBARRAY_HEIGHT, SUBARRAY_WIDTH);
    localparam int BW        = clog2(SERIAL_LEN);
    localparam int DW        = clog2(DRAIN_LEN + 1);
    localparam logic [BW-1:0] B_LAST = BW'(SERIAL_LEN - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_LEN - 1);

    if (SERIAL_LEN < 2 || SERIAL_LEN > 256) begin : g_bad_serial_len
        $error("j_array_sequencer: SERIAL_LEN must be in 2..256");
    end

    seq_state_t        state_q, state_d;
    logic [BW-1:0]     b_q;
    logic [W_NVEC-1:0] v_q;
    logic [DW-1:0]     d_q;
    logic [W_NVEC-1:0] nvec_q;
    logic [3:0]        mask_q;
    logic [3:0]        clr_base, end_base, mac_base;

    logic accept, b_last, v_last, d_last;
    assign accept = cmd_valid && cmd_ready;
    assign b_last = (b_q == B_LAST);
    assign v_last = (v_q == nvec_q - W_NVEC'(1));
    assign d_last = (d_q == D_LAST);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOADW;
            LOADW:   state_d = (nvec_q == '0) ? DRAIN : STREAM;
            STREAM:  if (b_last && v_last) state_d = DRAIN;
            DRAIN:   if (d_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nvec_q <= '0;
            mask_q <= '0;
            b_q    <= '0;
            v_q    <= '0;
            d_q    <= '0;
        end else begin
            if (accept) begin
                nvec_q <= cmd_nvec;
                mask_q <= cmd_lane_mask;
            end
            // b wraps straight into the next vector: no bubble between vectors.
            if (state_q == STREAM) begin
                if (b_last) begin
                    b_q <= '0;
                    v_q <= v_q + W_NVEC'(1);
                end else begin
                    b_q <= b_q + BW'(1);
                end
            end else begin
                b_q <= '0;
                v_q <= '0;
            end
            d_q <= (state_q == DRAIN) ? d_q + DW'(1) : '0;
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        update_w  = '0;
        clr_base  = '0;
        end_base  = '0;
        mac_base  = '0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            LOADW:  update_w = '1;
            STREAM: begin
                mac_base = mask_q;
                if (b_q == '0) clr_base = mask_q;
                if (b_last)    end_base = mask_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    logic [SKEW_W-1:0] row_base;
    assign row_base = {clr_base, end_base, mac_base};

    for (genvar j = 0; j < SUBARRAY_HEIGHT; j++) begin : g_row
        logic [SKEW_W-1:0] row_out;

        j_row_skew #(.N(j)) u_skew (
            .clk  (clk),
            .reset(reset),
            .din  (row_base),
            .dout (row_out)
        );

        assign clr_and_plus_one[4*j +: 4] = row_out[11:8];
        assign serial_end[4*j +: 4]       = row_out[7:4];
        assign mac_en[4*j +: 4]           = row_out[3:0];
    end

`ifdef J_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_jobs   <= '0;
        end else begin
            if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (done && perf_jobs != '1)   perf_jobs   <= perf_jobs + 16'd1;
        end
    end
`endif

endmodule

// File: doc/j_array_sequencer.md
Name: j_array_sequencer

Overview:
- Control sequencer for the bit-serial systolic subarray of j_MX_cell tiles.
- Accepts one job command through a valid/ready handshake, pulses the per-column weight update, then streams a number of bit-serial vectors.
- Generates the per-row 4-lane control buses: clr_and_plus_one, serial_end and mac_en. Row j is skewed by j cycles so each control wavefront stays aligned with its data.
- Reports job completion once the last wavefront has drained out of the right edge of the array.

Parameters:
- SUBARRAY_WIDTH, 1, number of array columns; sets the drain time.
- SUBARRAY_HEIGHT, 1, number of array rows; sets the per-row skew depth.
- SERIAL_LEN, 8, bit-serial cycles per vector (2..256).
- W_NVEC, 16, width of the vector-count field.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  job command valid
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_nvec  in  W_NVEC  number of vectors in the job; 0 is a legal empty job
- cmd_lane_mask  in  4  enabled lanes of each row's 4-bit control bus
- update_w  out  SUBARRAY_WIDTH  weight-update strobe per column
- clr_and_plus_one  out  4*SUBARRAY_HEIGHT  first-bit marker, row j at [4j+:4]
- serial_end  out  4*SUBARRAY_HEIGHT  last-bit marker per row
- mac_en  out  4*SUBARRAY_HEIGHT  accumulate enable per row
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - FSM goes to IDLE and all skew registers clear.
  - All outputs are 0 except cmd_ready=1.
- Reset asserted mid-job aborts the job with no done pulse. All control outputs read 0 on the cycle after the reset cycle.
- Handshake:
  - A command is accepted on the cycle where cmd_valid && cmd_ready.
  - cmd_nvec and cmd_lane_mask are latched on that cycle.
  - cmd_ready is 0 from the following cycle until the FSM returns to IDLE.
- FSM states:
  - IDLE: on accept, go to LOADW.
  - LOADW, 1 cycle: update_w = all ones. If the latched nvec==0, go to DRAIN; otherwise go to STREAM.
  - STREAM: a bit counter b runs 0..SERIAL_LEN-1 and a vector counter v runs 0..nvec-1.
    - Base (row-0) lane value = mask when active, else 0:
      - mac_en base = mask on every STREAM cycle.
      - clr base = mask when b==0.
      - end base = mask when b==SERIAL_LEN-1.
    - b wraps to 0 after SERIAL_LEN-1 and v then increments.
    - After the cycle with v==nvec-1 and b==SERIAL_LEN-1, go to DRAIN.
  - DRAIN: a counter runs for SUBARRAY_HEIGHT+SUBARRAY_WIDTH-1 cycles, then go to DONE.
  - DONE, 1 cycle: done=1, then go to IDLE. cmd_ready rises in the cycle after DONE.
- Skew:
  - Row j output = row-0 base value delayed by exactly j cycles, through a per-row shift register.
  - Row 0 is combinational from the FSM state and counters.
  - Skew registers shift every cycle in every state, so DRAIN flushes them to 0 naturally.
- Back-to-back vectors: clr (vector k+1, b=0) directly follows serial_end (vector k), with no bubble cycle.
- Counter widths:
  - b is clog2(SERIAL_LEN) bits.
  - v is W_NVEC bits.
  - nvec = 2^W_NVEC - 1 must not overflow v.
- SERIAL_LEN==1 is not supported; parameter check fails at elaboration.
- Total job latency, from the accept cycle to the done cycle: 1 + nvec*SERIAL_LEN + (H+W-1) + 1.

Optional Feature:
- Macro J_SEQ_PERF_CNT_EN.
- With the macro defined:
  - Adds output perf_cycles[31:0], counting cycles with busy=1.
  - Adds output perf_jobs[15:0], counting done pulses.
  - Both counters saturate at all-ones and clear on reset only.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package j_seq_pkg holds:
  - the state enum (IDLE, LOADW, STREAM, DRAIN, DONE);
  - the clog2 function;
  - the localparam DRAIN_LEN = SUBARRAY_HEIGHT + SUBARRAY_WIDTH - 1.
- One sub-module, j_row_skew: a parameterised depth-N, 12-bit-wide shift register carrying {clr, end, mac} × 4 lanes.
  - Synchronous reset to 0.
  - Instanced once per row with N=j.
  - N=0 is a pass-through.

Test Plan:
- H=2, W=2, SERIAL_LEN=4, nvec=1, mask=4'hF:
  - row 0 mac_en=F for 4 cycles starting the cycle after LOADW;
  - row 1 mac_en=F for the same 4 cycles delayed by 1;
  - clr on the first and serial_end on the last of those cycles;
  - done exactly 1+4+3+1 cycles after accept.
- nvec=3, SERIAL_LEN=4: mac_en is continuous for 12 cycles; clr occurs at b=0 of each vector, immediately following serial_end.
- mask=4'b0101: lanes 1 and 3 stay 0 on all three control buses for the whole job.
- nvec=0: update_w pulses once, no mac_en is asserted, and done arrives 1+3+1 cycles after accept.
- Reset asserted in mid-STREAM (v=1, b=2):
  - next cycle all outputs are 0 and cmd_ready=1;
  - no done pulse is produced;
  - a new command is accepted on the following cycle.
- cmd_valid held high continuously: jobs are accepted only in IDLE, with at least one cycle gap after done. With J_SEQ_PERF_CNT_EN defined, perf_jobs increments by 1 per job.
